// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the glorbcore fetch front end.
//   fetch_state_e : sequencer encoding (load program, issue words, program exhausted).
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_LOAD = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_imem.sv
// Local instruction memory: 2^IMW x IW RAM, one write port, registered read port.
//   clk, rst     : clock, synchronous active-high reset (clears only the read register)
//   we/waddr/wdata : write port
//   re/raddr     : read enable and address; rdata updates on the edge when re=1
//   rdata        : registered read data, holds while re=0
module instruction_fetch_imem #(
  parameter int unsigned IW  = 8,
  parameter int unsigned IMW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [IMW-1:0] waddr,
  input  logic [IW-1:0]  wdata,
  input  logic           re,
  input  logic [IMW-1:0] raddr,
  output logic [IW-1:0]  rdata
);

  logic [IW-1:0] mem_q [2**IMW];
  logic [IW-1:0] rdata_d, rdata_q;

  // Contents survive reset; every run starts with a fresh load.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: loads a program over a byte-stream handshake, then issues it in
// address order to decode with a one-deep registered output and stall support.
//   clk, rst                     : clock, synchronous active-high reset
//   load_valid/load_data/load_last/load_ready : program load handshake
//   stall                        : downstream backpressure, freezes issue
//   instruction/instr_valid      : registered word to decode
//   pc                           : address of the next word to fetch
//   halted                       : program exhausted, sticky until reset
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned IW  = 8,
  parameter int unsigned IMW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  input  logic [IW-1:0]  load_data,
  input  logic           load_last,
  output logic           load_ready,
  input  logic           stall,
  output logic [IW-1:0]  instruction,
  output logic           instr_valid,
  output logic [IMW-1:0] pc,
  output logic           halted
);

  fetch_state_e   state_d, state_q;
  logic [IMW-1:0] wr_ptr_d, wr_ptr_q;
  logic [IMW-1:0] pc_d, pc_q;
  logic [IMW-1:0] last_addr_d, last_addr_q;
  logic           instr_valid_d, instr_valid_q;
  logic           mem_we, mem_re;

  // No path from load_valid: ready depends only on state and reset.
  assign load_ready = (state_q == FETCH_LOAD) && !rst;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pc_d          = pc_q;
    last_addr_d   = last_addr_q;
    instr_valid_d = instr_valid_q;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    unique case (state_q)
      FETCH_LOAD: begin
        if (load_valid && load_ready) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + IMW'(1);
          // A full memory ends the load even without load_last.
          if (load_last || (wr_ptr_q == '1)) begin
            last_addr_d = wr_ptr_q;
            pc_d        = '0;
            state_d     = FETCH_RUN;
          end
        end
      end
      FETCH_RUN: begin
        if (!stall) begin
          mem_re        = 1'b1;
          instr_valid_d = 1'b1;
          // pc holds on the last word so it never wraps.
          if (pc_q == last_addr_q) begin
            state_d = FETCH_HALT;
          end else begin
            pc_d = pc_q + IMW'(1);
          end
        end
      end
      FETCH_HALT: begin
        // Last word stays presented until downstream takes it.
        if (!stall) begin
          instr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = FETCH_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_LOAD;
      wr_ptr_q      <= '0;
      pc_q          <= '0;
      last_addr_q   <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pc_q          <= pc_d;
      last_addr_q   <= last_addr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  instruction_fetch_imem #(
    .IW  (IW),
    .IMW (IMW)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (pc_q),
    .rdata (instruction)
  );

  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       stall;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(
    .IW  (8),
    .IMW (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .stall       (stall),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] ins, input logic vld,
                           input logic [3:0] p, input logic hlt);
    check({tag, ".instruction"}, 32'(instruction), 32'(ins));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
    check({tag, ".pc"},          32'(pc),          32'(p));
    check({tag, ".halted"},      32'(halted),      32'(hlt));
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'h00;
    stall      = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_beat(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
  endtask

  task automatic load_three();
    load_beat(8'h10, 1'b0);
    load_beat(8'h21, 1'b0);
    load_beat(8'h32, 1'b1);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00; stall = 1'b0;
    step();
    step();
    check_out("reset", 8'h00, 1'b0, 4'd0, 1'b0);
    check("reset.load_ready", 32'(load_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset.load_ready", 32'(load_ready), 32'd1);

    // Basic run
    load_three();
    check("basic.load_ready_run", 32'(load_ready), 32'd0);
    check_out("basic.run0", 8'h00, 1'b0, 4'd0, 1'b0);
    step(); check_out("basic.w0", 8'h10, 1'b1, 4'd1, 1'b0);
    step(); check_out("basic.w1", 8'h21, 1'b1, 4'd2, 1'b0);
    step(); check_out("basic.w2", 8'h32, 1'b1, 4'd2, 1'b1);
    step(); check_out("basic.done", 8'h32, 1'b0, 4'd2, 1'b1);

    // Stall mid-run, stall at halt, load port driven during RUN
    do_reset();
    load_three();
    load_valid = 1'b1;
    load_data  = 8'hFF;
    load_last  = 1'b1;
    check("ign.load_ready", 32'(load_ready), 32'd0);
    step(); check_out("ign.w0", 8'h10, 1'b1, 4'd1, 1'b0);
    step(); check_out("ign.w1", 8'h21, 1'b1, 4'd2, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_out("stall.mid", 8'h21, 1'b1, 4'd2, 1'b0);
    end
    stall = 1'b0;
    step(); check_out("stall.resume", 8'h32, 1'b1, 4'd2, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); check_out("stall.halt", 8'h32, 1'b1, 4'd2, 1'b1);
    end
    stall = 1'b0;
    step(); check_out("stall.release", 8'h32, 1'b0, 4'd2, 1'b1);
    check("ign.load_ready_halt", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    load_last  = 1'b0;

    // Reset mid-RUN
    do_reset();
    load_three();
    step(); check_out("rstrun.w0", 8'h10, 1'b1, 4'd1, 1'b0);
    rst = 1'b1;
    step();
    check_out("rstrun.abort", 8'h00, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    #1;
    check("rstrun.load_ready", 32'(load_ready), 32'd1);

    // Full load: 16 beats, load_last never asserted
    for (int k = 0; k < 16; k++) begin
      check("full.ready_before", 32'(load_ready), 32'd1);
      load_beat(8'(k), 1'b0);
    end
    load_valid = 1'b0;
    check("full.ready_after", 32'(load_ready), 32'd0);
    check("full.pc_start", 32'(pc), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      check_out("full.issue", 8'(k), 1'b1, (k == 15) ? 4'd15 : 4'(k + 1), (k == 15));
    end
    step(); check_out("full.done", 8'd15, 1'b0, 4'd15, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
